// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the microRISC hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W  = 3;
  localparam int WAIT_W = 16;
  localparam logic [REG_W-1:0] ZERO_REG = 3'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_e;

  // r0 is hardwired to zero, so a load targeting it can never feed a consumer.
  function automatic logic load_use(
    input logic             mem_read,
    input logic [REG_W-1:0] dest,
    input logic [REG_W-1:0] rs,
    input logic             use_rs,
    input logic [REG_W-1:0] rt,
    input logic             use_rt
  );
    return mem_read && (dest != ZERO_REG) &&
           ((use_rs && (rs == dest)) || (use_rt && (rt == dest)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for load-use, taken-branch and memory-busy hazards.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);

  hz_state_e         state_q, state_d;
  logic              pend_q, pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              lu;

  assign lu = load_use(ex_mem_read, ex_dest, id_rs, id_use_rs, id_rt, id_use_rt);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    wait_d       = wait_q;
    err_d        = err_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          pend_d  = ex_branch_taken;
          wait_d  = 16'd1;
          state_d = MEM_WAIT;
        end else if (ex_branch_taken) begin
          {if_id_flush, id_ex_flush} = 2'b11;
        end else if (lu) begin
          {pc_stall, if_id_stall, id_ex_flush} = 3'b111;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
          pend_d = pend_q | ex_branch_taken;
          wait_d = wait_q + 16'd1;
          if (wait_q >= TIMEOUT_LIM) begin
            state_d = TIMEOUT;
            err_d   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          // The release cycle is unstalled; a branch seen during the wait wins.
          if (pend_q || ex_branch_taken) begin
            {if_id_flush, id_ex_flush} = 2'b11;
          end else if (lu) begin
            {pc_stall, if_id_stall, id_ex_flush} = 3'b111;
          end else begin
            pend_d = 1'b0;
          end
          pend_d  = 1'b0;
          wait_d  = 16'd0;
          state_d = RUN;
        end
      end
      TIMEOUT: begin
        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'b1111;
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
        wait_d  = 16'd0;
      end
    endcase
  end

  // Controller state, pending-branch latch, watchdog and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_stall),
    .cnt_o (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (id_ex_flush),
    .cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
